// File: rtl/sel_enc_pkg.sv
// Field-position helpers for the select/encode unit: IR field offsets and index width.
package sel_enc_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Ra sits directly below the opcode; Rb and Rc follow, each one index width lower.
  function automatic int ra_hi(input int ir_w, input int op_w);
    return ir_w - op_w - 1;
  endfunction

  function automatic int rb_hi(input int ir_w, input int op_w, input int idx_w);
    return ra_hi(ir_w, op_w) - idx_w;
  endfunction

  function automatic int rc_hi(input int ir_w, input int op_w, input int idx_w);
    return rb_hi(ir_w, op_w, idx_w) - idx_w;
  endfunction

  function automatic int c_w(input int ir_w, input int op_w, input int idx_w);
    return ir_w - op_w - 2 * idx_w;
  endfunction

endpackage

// File: rtl/sel_enc_reg_onehot_dec.sv
// Index-to-one-hot decoder; all zeros when not enabled.
module onehot_dec #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/sel_enc_reg.sv
// Registered register-file select/encode: IR copy, Ra/Rb/Rc decode to one-hot
// write/read enables, R0 base-address zeroing, optional R0 write protect, sticky select error.
module sel_enc_reg
  import sel_enc_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IR_W     = 32,
  parameter int OP_W     = 5,
  parameter int DATA_W   = 32,
  parameter int R0_WP    = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ir_load,
  input  logic [IR_W-1:0]     ir_in,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                ba_out,
  output logic [NUM_REGS-1:0] rins,
  output logic [NUM_REGS-1:0] routs,
  output logic                r0_zero,
  output logic [DATA_W-1:0]   c_sign_ext,
  output logic                sel_err
);

  localparam int IDX_W = clog2(NUM_REGS);
  localparam int RA_HI = ra_hi(IR_W, OP_W);
  localparam int RB_HI = rb_hi(IR_W, OP_W, IDX_W);
  localparam int RC_HI = rc_hi(IR_W, OP_W, IDX_W);
  localparam int C_W   = c_w(IR_W, OP_W, IDX_W);

  logic [IR_W-1:0]     ir_q, ir_d;
  logic [NUM_REGS-1:0] rins_q, rins_d;
  logic [NUM_REGS-1:0] routs_q, routs_d;
  logic                r0_zero_q, r0_zero_d;
  logic                sel_err_q, sel_err_d;

  logic [IDX_W-1:0] idx;
  logic [1:0]       nsel;
  logic             single, zero_hit, wr_en, rd_en, err_new;

  // The opcode field belongs to the control unit; it is carried in ir_q but not decoded here.
  logic unused_op;
  assign unused_op = ^ir_q[IR_W-1 -: OP_W];

  always_comb begin
    ir_d   = ir_load ? ir_in : ir_q;
    nsel   = {1'b0, gra} + {1'b0, grb} + {1'b0, grc};
    single = (nsel == 2'd1);
    idx    = '0;
    if (gra)      idx = ir_q[RA_HI -: IDX_W];
    else if (grb) idx = ir_q[RB_HI -: IDX_W];
    else if (grc) idx = ir_q[RC_HI -: IDX_W];

    zero_hit  = ba_out && rout && single && (idx == '0);
    wr_en     = single && rin && !((R0_WP != 0) && (idx == '0));
    rd_en     = single && rout && !zero_hit;
    err_new   = (nsel > 2'd1) && (rin || rout);
    r0_zero_d = zero_hit;
    // A new error in the same cycle as ir_load must remain visible.
    if (err_new)      sel_err_d = 1'b1;
    else if (ir_load) sel_err_d = 1'b0;
    else              sel_err_d = sel_err_q;
  end

  onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rin_dec (
    .idx    (idx),
    .en     (wr_en),
    .onehot (rins_d)
  );

  onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rout_dec (
    .idx    (idx),
    .en     (rd_en),
    .onehot (routs_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q      <= '0;
      rins_q    <= '0;
      routs_q   <= '0;
      r0_zero_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      rins_q    <= rins_d;
      routs_q   <= routs_d;
      r0_zero_q <= r0_zero_d;
      sel_err_q <= sel_err_d;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_sext
    if (i < C_W) begin : g_fld
      assign c_sign_ext[i] = ir_q[i];
    end else begin : g_ext
      assign c_sign_ext[i] = ir_q[C_W-1];
    end
  end

  assign rins    = rins_q;
  assign routs   = routs_q;
  assign r0_zero = r0_zero_q;
  assign sel_err = sel_err_q;

endmodule
